// File: rtl/apb_master_if.sv
// Command/response and APB3 bus bundle for apb_master.
// The master modport is the initiator's view; slave is the bench/host view.
interface apb_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic                  rsp_timeout;
    logic                  pselx;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
               pselx, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
               pselx, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// APB3 initiator: one command in flight, all APB and response outputs registered.
// Optional ACCESS-phase watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            pclk_i,
    input  logic            preset_i,
    apb_master_if.master    apb
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_s;
`endif

    // Next-state and registered-output computation for the transfer FSM
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_s     = (wait_cnt_q == CNT_LAST) && !apb.pready;
`endif
        case (state_q)
            ST_IDLE: begin
                if (apb.cmd_valid && cmd_ready_q) begin
                    pwrite_d    = apb.cmd_write;
                    paddr_d     = apb.cmd_addr;
                    pwdata_d    = apb.cmd_wdata;
                    psel_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt_d  = {CNT_W{1'b0}};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY on the watchdog's last edge still counts as a normal completion
                if (apb.pready) begin
                    rsp_rdata_d   = pwrite_q ? {DATA_WIDTH{1'b0}} : apb.prdata;
                    rsp_error_d   = apb.pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = ST_RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (timeout_s) begin
                    rsp_rdata_d   = {DATA_WIDTH{1'b0}};
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`else
                else begin
                    state_d = ST_ACCESS;
                end
`endif
            end
            ST_RESP: begin
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= {ADDR_WIDTH{1'b0}};
            pwdata_q      <= {DATA_WIDTH{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= {DATA_WIDTH{1'b0}};
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q    <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
`endif
        end
    end

    assign apb.cmd_ready   = cmd_ready_q;
    assign apb.pselx       = psel_q;
    assign apb.penable     = penable_q;
    assign apb.pwrite      = pwrite_q;
    assign apb.paddr       = paddr_q;
    assign apb.pwdata      = pwdata_q;
    assign apb.rsp_valid   = rsp_valid_q;
    assign apb.rsp_rdata   = rsp_rdata_q;
    assign apb.rsp_error   = rsp_error_q;
    assign apb.rsp_timeout = rsp_timeout_q;
endmodule
